// File: rtl/jtopl_wr_sched_if.sv
// Write-request and update-strobe bundle between the CPU register decoder,
// the write scheduler and the per-operator register shift chain.
interface jtopl_wr_sched_if #(
    parameter int RW = 3,
    parameter int DW = 8
);
    logic          wr_req;
    logic [3:0]    wr_ch;
    logic          wr_op;
    logic [RW-1:0] wr_reg;
    logic [DW-1:0] wr_din;
    logic          full;
    logic          empty;
    logic          err;
    logic          upd_en;
    logic [RW-1:0] upd_reg;
    logic [DW-1:0] upd_din;

    modport master (
        output wr_req, wr_ch, wr_op, wr_reg, wr_din,
        input  full, empty, err, upd_en, upd_reg, upd_din
    );

    modport slave (
        input  wr_req, wr_ch, wr_op, wr_reg, wr_din,
        output full, empty, err, upd_en, upd_reg, upd_din
    );
endinterface

// File: rtl/jtopl_wr_sched.sv
// Queues CPU operator-register writes and releases each one as a strobe
// spanning exactly the slot period of its target operator.
//
// state | meaning
// IDLE  | FIFO empty, nothing to issue
// WAIT  | head entry waits for the slot counter to reach its target slot
module jtopl_wr_sched #(
    parameter int DEPTH = 4,
    parameter int RW    = 3,
    parameter int DW    = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            cen,
    input  logic [1:0]      group,
    input  logic [2:0]      subslot,
    jtopl_wr_sched_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int EW = 5 + RW + DW;

    typedef enum logic {IDLE, WAIT} state_t;
    state_t state, state_nxt;

    logic [EW-1:0] mem [DEPTH];
    logic [AW:0]   wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt;
    logic          full, empty, push, pop;
    logic [1:0]    tgt_grp;
    logic [2:0]    ch_mod, tgt_sub;
    logic [1:0]    ngrp;
    logic [2:0]    nsub;
    logic [4:0]    head_tgt;
    logic [RW-1:0] head_reg;
    logic [DW-1:0] head_din;
    logic          err, upd_en;
    logic [RW-1:0] upd_reg;
    logic [DW-1:0] upd_din;

    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty = (wr_ptr == rd_ptr);
    assign push  = bus.wr_req && !full && (bus.wr_ch <= 4'd8);

    always_comb begin
        tgt_grp = 2'd0;
        ch_mod  = 3'd0;
        case (bus.wr_ch)
            4'd1: ch_mod = 3'd1;
            4'd2: ch_mod = 3'd2;
            4'd3: tgt_grp = 2'd1;
            4'd4: begin tgt_grp = 2'd1; ch_mod = 3'd1; end
            4'd5: begin tgt_grp = 2'd1; ch_mod = 3'd2; end
            4'd6: tgt_grp = 2'd2;
            4'd7: begin tgt_grp = 2'd2; ch_mod = 3'd1; end
            4'd8: begin tgt_grp = 2'd2; ch_mod = 3'd2; end
            default: ;
        endcase
    end

    assign tgt_sub = ch_mod + (bus.wr_op ? 3'd3 : 3'd0);

    // Compare against the slot the counter moves to on this cen edge, so the
    // registered strobe lines up with the counter showing the target slot.
    assign nsub = (subslot == 3'd5) ? 3'd0 : subslot + 3'd1;
    assign ngrp = (subslot != 3'd5) ? group :
                  (group == 2'd2)   ? 2'd0  : group + 2'd1;

    assign {head_tgt, head_reg, head_din} = mem[rd_ptr[AW-1:0]];
    assign pop = (state == WAIT) && cen && (head_tgt == {ngrp, nsub});

    assign wr_ptr_nxt = wr_ptr + {{AW{1'b0}}, push};
    assign rd_ptr_nxt = rd_ptr + {{AW{1'b0}}, pop};

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= {tgt_grp, tgt_sub, bus.wr_reg, bus.wr_din};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            err    <= 1'b0;
        end else begin
            wr_ptr <= wr_ptr_nxt;
            rd_ptr <= rd_ptr_nxt;
            err    <= bus.wr_req && !push;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            upd_en  <= 1'b0;
            upd_reg <= '0;
            upd_din <= '0;
        end else if (cen) begin
            upd_en <= pop;
            if (pop) begin
                upd_reg <= head_reg;
                upd_din <= head_din;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (push) state_nxt = WAIT;
            WAIT: if (wr_ptr_nxt == rd_ptr_nxt) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.full    = full;
    assign bus.empty   = empty;
    assign bus.err     = err;
    assign bus.upd_en  = upd_en;
    assign bus.upd_reg = upd_reg;
    assign bus.upd_din = upd_din;
endmodule

// File: tb/tb_jtopl_wr_sched.sv
// Directed bench for jtopl_wr_sched: expected strobes are queued at push time
// and a monitor compares each strobe against the queue head.
module tb_jtopl_wr_sched;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       cen;
    logic [1:0] group   = 2'd0;
    logic [2:0] subslot = 3'd0;
    int         cen_cnt = 0;

    int n_cmp = 0;
    int n_bad = 0;
    int hi_cnt = 0;

    typedef struct packed {
        logic [1:0] g;
        logic [2:0] s;
        logic [2:0] r;
        logic [7:0] d;
    } exp_t;

    exp_t exp_q[$];
    int   strobe_cen[$];

    jtopl_wr_sched_if #(.RW(3), .DW(8)) bus ();

    jtopl_wr_sched #(.DEPTH(4), .RW(3), .DW(8)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .cen     (cen),
        .group   (group),
        .subslot (subslot),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // Reference slot counter: 6 subslots per group, 3 groups per frame.
    always @(posedge clk) begin
        if (cen) begin
            if (subslot == 3'd5) begin
                subslot <= 3'd0;
                group   <= (group == 2'd2) ? 2'd0 : group + 2'd1;
            end else begin
                subslot <= subslot + 3'd1;
            end
            cen_cnt <= cen_cnt + 1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic run_cen(input int n, input int per);
        for (int i = 0; i < n; i++) begin
            cen = 1'b1;
            @(negedge clk);
            if (per > 1) begin
                cen = 1'b0;
                repeat (per - 1) @(negedge clk);
            end
        end
        cen = 1'b0;
    endtask

    task automatic goto_slot(input logic [1:0] g, input logic [2:0] s);
        int n = 0;
        while (!(group == g && subslot == s) && n < 20) begin
            run_cen(1, 1);
            n++;
        end
        check("goto_slot", {27'd0, group, subslot}, {27'd0, g, s});
    endtask

    task automatic push(input logic [3:0] ch, input logic op, input logic [2:0] r,
                        input logic [7:0] d, input logic ok,
                        input logic [1:0] g, input logic [2:0] s);
        exp_t e;
        @(negedge clk);
        bus.wr_req = 1'b1;
        bus.wr_ch  = ch;
        bus.wr_op  = op;
        bus.wr_reg = r;
        bus.wr_din = d;
        if (ok) begin
            e.g = g; e.s = s; e.r = r; e.d = d;
            exp_q.push_back(e);
        end
        @(negedge clk);
        bus.wr_req = 1'b0;
        check("err_flag", {31'd0, bus.err}, {31'd0, !ok});
    endtask

    // Monitor: a strobe is upd_en high right after a cen edge; between cen
    // edges the strobe must hold and stay within its target slot.
    initial begin
        logic       cen_s;
        logic       prev_en;
        logic [4:0] last_slot;
        exp_t       e;
        prev_en   = 1'b0;
        last_slot = 5'd0;
        forever begin
            @(posedge clk);
            cen_s = cen;
            #1;
            if (bus.upd_en) hi_cnt++;
            if (cen_s && bus.upd_en) begin
                strobe_cen.push_back(cen_cnt);
                last_slot = {group, subslot};
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_strobe: got slot {%0d,%0d} din 0x%0h, expected no strobe",
                             group, subslot, bus.upd_din);
                end else begin
                    e = exp_q.pop_front();
                    check("strobe_slot", {27'd0, group, subslot}, {27'd0, e.g, e.s});
                    check("strobe_reg",  {29'd0, bus.upd_reg}, {29'd0, e.r});
                    check("strobe_din",  {24'd0, bus.upd_din}, {24'd0, e.d});
                end
            end else if (!cen_s && rst_n && (bus.upd_en || prev_en)) begin
                check("strobe_hold", {31'd0, bus.upd_en}, {31'd0, prev_en});
                if (bus.upd_en) check("strobe_span_slot", {27'd0, group, subslot}, {27'd0, last_slot});
            end
            prev_en = bus.upd_en;
        end
    end

    initial begin
        rst_n      = 1'b0;
        cen        = 1'b0;
        bus.wr_req = 1'b0;
        bus.wr_ch  = 4'd0;
        bus.wr_op  = 1'b0;
        bus.wr_reg = 3'd0;
        bus.wr_din = 8'd0;
        repeat (2) @(negedge clk);
        check("rst_empty",   {31'd0, bus.empty},  32'd1);
        check("rst_full",    {31'd0, bus.full},   32'd0);
        check("rst_err",     {31'd0, bus.err},    32'd0);
        check("rst_upd_en",  {31'd0, bus.upd_en}, 32'd0);
        check("rst_upd_reg", {29'd0, bus.upd_reg}, 32'd0);
        check("rst_upd_din", {24'd0, bus.upd_din}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single write: ch4/op1 -> slot {1,4}
        hi_cnt = 0;
        push(4'd4, 1'b1, 3'd2, 8'h5A, 1'b1, 2'd1, 3'd4);
        run_cen(25, 1);
        check("single_drained", exp_q.size(), 32'd0);
        check("single_empty", {31'd0, bus.empty}, 32'd1);
        check("single_span", hi_cnt, 32'd1);

        // Ordering: {0,0} then {2,5} of the same frame
        goto_slot(2'd2, 3'd5);
        strobe_cen.delete();
        push(4'd0, 1'b0, 3'd1, 8'h33, 1'b1, 2'd0, 3'd0);
        push(4'd8, 1'b1, 3'd5, 8'hC8, 1'b1, 2'd2, 3'd5);
        run_cen(25, 1);
        check("order_count", strobe_cen.size(), 32'd2);
        if (strobe_cen.size() == 2) check("order_gap", strobe_cen[1] - strobe_cen[0], 32'd17);

        // Same slot twice: ch1/op0 -> {0,1}, one frame apart
        strobe_cen.delete();
        push(4'd1, 1'b0, 3'd3, 8'h11, 1'b1, 2'd0, 3'd1);
        push(4'd1, 1'b0, 3'd3, 8'h22, 1'b1, 2'd0, 3'd1);
        run_cen(45, 1);
        check("same_count", strobe_cen.size(), 32'd2);
        if (strobe_cen.size() == 2) check("same_gap", strobe_cen[1] - strobe_cen[0], 32'd18);

        // Full: four accepted, fifth dropped with err
        strobe_cen.delete();
        push(4'd2, 1'b0, 3'd1, 8'hA1, 1'b1, 2'd0, 3'd2);
        push(4'd3, 1'b1, 3'd2, 8'hA2, 1'b1, 2'd1, 3'd3);
        push(4'd5, 1'b0, 3'd3, 8'hA3, 1'b1, 2'd1, 3'd2);
        check("full_after3", {31'd0, bus.full}, 32'd0);
        push(4'd7, 1'b1, 3'd4, 8'hA4, 1'b1, 2'd2, 3'd4);
        check("full_after4", {31'd0, bus.full}, 32'd1);
        push(4'd0, 1'b0, 3'd7, 8'hFF, 1'b0, 2'd0, 3'd0);
        check("full_still", {31'd0, bus.full}, 32'd1);
        run_cen(90, 1);
        check("full_strobes", strobe_cen.size(), 32'd4);
        check("full_empty", {31'd0, bus.empty}, 32'd1);

        // Invalid channel
        strobe_cen.delete();
        push(4'd9, 1'b0, 3'd1, 8'h99, 1'b0, 2'd0, 3'd0);
        check("inv_empty", {31'd0, bus.empty}, 32'd1);
        run_cen(36, 1);
        check("inv_no_strobe", strobe_cen.size(), 32'd0);

        // cen gated 1-in-3: strobe covers exactly one slot period (3 clocks)
        strobe_cen.delete();
        hi_cnt = 0;
        push(4'd6, 1'b0, 3'd4, 8'h66, 1'b1, 2'd2, 3'd0);
        run_cen(40, 3);
        check("gate_strobes", strobe_cen.size(), 32'd1);
        check("gate_span", hi_cnt, 32'd3);

        // Reset while waiting with three entries queued
        strobe_cen.delete();
        push(4'd0, 1'b1, 3'd1, 8'hB1, 1'b1, 2'd0, 3'd3);
        push(4'd4, 1'b0, 3'd2, 8'hB2, 1'b1, 2'd1, 3'd1);
        push(4'd8, 1'b0, 3'd3, 8'hB3, 1'b1, 2'd2, 3'd2);
        check("pre_rst_empty", {31'd0, bus.empty}, 32'd0);
        rst_n = 1'b0;
        #1;
        check("mid_rst_empty", {31'd0, bus.empty}, 32'd1);
        check("mid_rst_upd_en", {31'd0, bus.upd_en}, 32'd0);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        run_cen(40, 1);
        check("post_rst_no_strobe", strobe_cen.size(), 32'd0);
        check("post_rst_empty", {31'd0, bus.empty}, 32'd1);

        check("final_drained", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
